// File: rtl/unified_sync_memory_pkg.sv
// Shared types and helpers for the TSP16 unified instruction/data memory.
package mem_pkg;

   typedef enum logic {CLEAR, RUN} mem_state_e;

   // Widest word the strobe-merge helper handles; callers zero-extend and truncate.
   localparam int MAX_W = 256;
   localparam int MAX_S = MAX_W / 8;

   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic logic [MAX_W-1:0] merge_strobe(input logic [MAX_W-1:0] old_w,
                                                     input logic [MAX_W-1:0] new_w,
                                                     input logic [MAX_S-1:0] strb);
      logic [MAX_W-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_S; i++)
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/unified_sync_memory_clear_seq.sv
// Post-reset sequencer: sweeps the array with zero writes, then reports ready.
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   mem_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               // Last sweep cycle writes the top address; RUN starts on the next edge.
               if (&cnt_q) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN:     ready_q <= 1'b1;
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign clr_we   = (state_q == CLEAR);
   assign clr_addr = cnt_q;
   assign ready    = ready_q;

endmodule

// File: rtl/unified_sync_memory.sv
// Unified sync-read memory: byte-strobed write, data read, dual-word fetch, all 1-cycle.
module unified_sync_memory
   import mem_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int STRB_W        = strb_width(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ready,
   input  logic              write,
   input  logic [STRB_W-1:0] write_strobe,
   input  logic [ADDR_W-1:0] write_address,
   input  logic [DATA_W-1:0] write_input,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] read_address,
   output logic [DATA_W-1:0] read_output,
   output logic              read_valid,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] next_pc,
   output logic [DATA_W-1:0] fetch_instr,
   output logic [DATA_W-1:0] fetch_next_instr,
   output logic              fetch_valid
);

   // Read ports: 0 = data read, 1 = pc, 2 = next_pc.
   localparam int NPORT = 3;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_acc;
   logic [DATA_W-1:0] wr_merged;

   logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
   logic [NPORT-1:0]             rd_en;
   logic [NPORT-1:0][DATA_W-1:0] rd_d, rd_q;
   logic [1:0]                   vld_q;

   mem_clear_seq #(
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   assign wr_acc    = ready & write;
   assign wr_merged = DATA_W'(merge_strobe(MAX_W'(mem_q[write_address]),
                                           MAX_W'(write_input),
                                           MAX_S'(write_strobe)));

   // Array is deliberately left out of reset; the clear sweep owns initialisation.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem_q[clr_addr] <= '0;
      else if (wr_acc)
         mem_q[write_address] <= wr_merged;
   end

   assign rd_addr = {next_pc, pc, read_address};
   assign rd_en   = {fetch_en, fetch_en, read_en};

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      // Same-cycle write is forwarded so a read sees the strobe-merged word.
      assign rd_d[p] = (wr_acc && rd_addr[p] == write_address) ? wr_merged
                                                               : mem_q[rd_addr[p]];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                  rd_q[p] <= '0;
         else if (ready && rd_en[p])  rd_q[p] <= rd_d[p];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= {ready & fetch_en, ready & read_en};
   end

   assign read_output      = rd_q[0];
   assign fetch_instr      = rd_q[1];
   assign fetch_next_instr = rd_q[2];
   assign read_valid       = vld_q[0];
   assign fetch_valid      = vld_q[1];

endmodule

// File: tb/tb_unified_sync_memory.sv
// Randomised bench for unified_sync_memory against a word-array reference model.
module tb_unified_sync_memory;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int SW = 2;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b1;
   logic          ready, write, read_en, fetch_en, read_valid, fetch_valid;
   logic [SW-1:0] write_strobe;
   logic [AW-1:0] write_address, read_address, pc, next_pc;
   logic [DW-1:0] write_input, read_output, fetch_instr, fetch_next_instr;

   logic          n_rst_n = 1'b1;
   logic          n_ready, n_write, n_read_en, n_fetch_en, n_read_valid, n_fetch_valid;
   logic [SW-1:0] n_write_strobe;
   logic [AW-1:0] n_write_address, n_read_address, n_pc, n_next_pc;
   logic [DW-1:0] n_write_input, n_read_output, n_fetch_instr, n_fetch_next_instr;

   unified_sync_memory #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ready(ready),
      .write(write), .write_strobe(write_strobe), .write_address(write_address),
      .write_input(write_input), .read_en(read_en), .read_address(read_address),
      .read_output(read_output), .read_valid(read_valid), .fetch_en(fetch_en),
      .pc(pc), .next_pc(next_pc), .fetch_instr(fetch_instr),
      .fetch_next_instr(fetch_next_instr), .fetch_valid(fetch_valid));

   unified_sync_memory #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_nc (
      .clk(clk), .rst_n(n_rst_n), .ready(n_ready),
      .write(n_write), .write_strobe(n_write_strobe), .write_address(n_write_address),
      .write_input(n_write_input), .read_en(n_read_en), .read_address(n_read_address),
      .read_output(n_read_output), .read_valid(n_read_valid), .fetch_en(n_fetch_en),
      .pc(n_pc), .next_pc(n_next_pc), .fetch_instr(n_fetch_instr),
      .fetch_next_instr(n_fetch_next_instr), .fetch_valid(n_fetch_valid));

   int vecs = 0;
   int errs = 0;

   logic [DW-1:0] mdl [DEPTH];
   logic [DW-1:0] e_ro, e_fi, e_fn;

   task automatic idle();
      write = 1'b0; write_strobe = '0; write_address = '0; write_input = '0;
      read_en = 1'b0; read_address = '0; fetch_en = 1'b0; pc = '0; next_pc = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      e_ro = '0; e_fi = '0; e_fn = '0;
   endtask

   // One RUN-mode cycle: drive, update model (write lands first, so reads see it), check.
   task automatic apply(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic fe, input logic [AW-1:0] p, input logic [AW-1:0] np,
                        input string tag);
      write = w; write_strobe = s; write_address = wa; write_input = wd;
      read_en = re; read_address = ra; fetch_en = fe; pc = p; next_pc = np;
      if (w)
         for (int b = 0; b < SW; b++)
            if (s[b]) mdl[wa][8*b +: 8] = wd[8*b +: 8];
      if (re) e_ro = mdl[ra];
      if (fe) begin e_fi = mdl[p]; e_fn = mdl[np]; end
      @(posedge clk); #1;
      idle();
      vecs++;
      if (read_valid !== re) begin
         errs++; $display("FAIL %s read_valid got %b exp %b", tag, read_valid, re);
      end
      vecs++;
      if (read_output !== e_ro) begin
         errs++; $display("FAIL %s read_output got %h exp %h", tag, read_output, e_ro);
      end
      vecs++;
      if (fetch_valid !== fe) begin
         errs++; $display("FAIL %s fetch_valid got %b exp %b", tag, fetch_valid, fe);
      end
      vecs++;
      if (fetch_instr !== e_fi) begin
         errs++; $display("FAIL %s fetch_instr got %h exp %h", tag, fetch_instr, e_fi);
      end
      vecs++;
      if (fetch_next_instr !== e_fn) begin
         errs++; $display("FAIL %s fetch_next_instr got %h exp %h", tag, fetch_next_instr, e_fn);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      vecs++;
      if ({ready, read_valid, fetch_valid} !== 3'b000 || read_output !== '0 ||
          fetch_instr !== '0 || fetch_next_instr !== '0) begin
         errs++;
         $display("FAIL %s outputs rdy/rv/fv=%b%b%b ro=%h fi=%h fn=%h exp all 0", tag,
                  ready, read_valid, fetch_valid, read_output, fetch_instr, fetch_next_instr);
      end
   endtask

   // Release must already have happened; counts edges until ready, while hammering requests.
   task automatic wait_clear(input string tag);
      int rise;
      rise = 0;
      for (int i = 1; i <= 40; i++) begin
         write = 1'b1; write_strobe = 2'b11; write_input = 16'hFFFF;
         write_address = AW'($urandom_range(0, DEPTH-1));
         read_en = 1'b1; read_address = AW'($urandom_range(0, DEPTH-1));
         fetch_en = 1'b1; pc = read_address; next_pc = write_address;
         @(posedge clk); #1;
         vecs++;
         if (read_valid !== 1'b0 || fetch_valid !== 1'b0) begin
            errs++; $display("FAIL %s valid during clear rv=%b fv=%b exp 0", tag, read_valid, fetch_valid);
         end
         if (ready === 1'b1) begin rise = i; break; end
      end
      idle();
      vecs++;
      if (rise != DEPTH) begin
         errs++; $display("FAIL %s ready rise after %0d cycles exp %0d", tag, rise, DEPTH);
      end
      model_clear();
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < DEPTH; a++)
         apply(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(a), AW'(a ^ 1), tag);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      wait_clear("reset_clear");
      read_all("reset_readback");
   endtask

   task automatic test_strobes();
      apply(1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, '0, 1'b0, '0, '0, "strb_w0");
      apply(1'b1, 2'b10, 4'd3, 16'h1200, 1'b0, '0, 1'b0, '0, '0, "strb_w1");
      apply(1'b1, 2'b00, 4'd3, 16'hFFFF, 1'b0, '0, 1'b0, '0, '0, "strb_zero");
      apply(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0, '0, '0, "strb_rd");
      vecs++;
      if (read_output !== 16'h12CD) begin
         errs++; $display("FAIL strb_const read_output got %h exp 12cd", read_output);
      end
   endtask

   task automatic test_forward();
      apply(1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, '0, 1'b0, '0, '0, "fwd_w5");
      apply(1'b1, 2'b11, 4'd6, 16'h2222, 1'b0, '0, 1'b0, '0, '0, "fwd_w6");
      apply(1'b1, 2'b01, 4'd5, 16'h00EE, 1'b1, 4'd5, 1'b1, 4'd5, 4'd6, "fwd");
      vecs++;
      if (read_output !== 16'h11EE || fetch_instr !== 16'h11EE || fetch_next_instr !== 16'h2222) begin
         errs++; $display("FAIL fwd_const ro=%h fi=%h fn=%h exp 11ee 11ee 2222",
                          read_output, fetch_instr, fetch_next_instr);
      end
      // next_pc forwarding with pc == next_pc
      apply(1'b1, 2'b10, 4'd6, 16'h7700, 1'b0, '0, 1'b1, 4'd6, 4'd6, "fwd_np");
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) begin
         apply(1'b1, 2'b11, AW'(a), DW'($urandom), 1'b0, '0, 1'b0, '0, '0, "b2b_w");
      end
      for (int a = 0; a < 4; a++)
         apply(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(3 - a), AW'(a + 8), "b2b_rd");
      apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, "b2b_hold0");
      apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, "b2b_hold1");
   endtask

   task automatic test_random();
      logic [AW-1:0] wa, ra, p, np;
      for (int n = 0; n < 300; n++) begin
         wa = AW'($urandom_range(0, DEPTH-1));
         ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
         p  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
         np = ($urandom_range(0, 2) == 0) ? p  : AW'(p + 1);
         apply(1'($urandom), SW'($urandom), wa, DW'($urandom), 1'($urandom), ra,
               1'($urandom), p, np, "rand");
      end
      apply(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b1, 4'd10, 4'd11, "rand_last");
   endtask

   task automatic test_reset_midclear();
      rst_n = 1'b0;
      #1;
      check_outputs_zero("run_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midclear_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_clear("midclear");
      read_all("midclear_readback");
   endtask

   task automatic test_noclear();
      @(posedge clk); #1;
      vecs++;
      if (n_ready !== 1'b0) begin
         errs++; $display("FAIL nc_reset ready got %b exp 0", n_ready);
      end
      n_rst_n = 1'b1;
      n_read_en = 1'b1; n_read_address = 4'd0;
      @(posedge clk); #1;
      vecs++;
      if (n_ready !== 1'b1 || n_read_valid !== 1'b0) begin
         errs++; $display("FAIL nc_rise ready=%b read_valid=%b exp 1 0", n_ready, n_read_valid);
      end
      n_write = 1'b1; n_write_strobe = 2'b11; n_write_address = 4'd4; n_write_input = 16'hBEEF;
      n_read_en = 1'b1; n_read_address = 4'd4;
      @(posedge clk); #1;
      n_write = 1'b0;
      vecs++;
      if (n_read_valid !== 1'b1 || n_read_output !== 16'hBEEF) begin
         errs++; $display("FAIL nc_fwd rv=%b ro=%h exp 1 beef", n_read_valid, n_read_output);
      end
      n_fetch_en = 1'b1; n_pc = 4'd4; n_next_pc = 4'd4; n_read_en = 1'b0;
      @(posedge clk); #1;
      n_fetch_en = 1'b0;
      vecs++;
      if (n_fetch_valid !== 1'b1 || n_fetch_instr !== 16'hBEEF || n_fetch_next_instr !== 16'hBEEF ||
          n_read_valid !== 1'b0 || n_read_output !== 16'hBEEF) begin
         errs++; $display("FAIL nc_fetch fv=%b fi=%h fn=%h rv=%b ro=%h exp 1 beef beef 0 beef",
                          n_fetch_valid, n_fetch_instr, n_fetch_next_instr, n_read_valid, n_read_output);
      end
   endtask

   initial begin
      idle();
      n_write = 1'b0; n_write_strobe = '0; n_write_address = '0; n_write_input = '0;
      n_read_en = 1'b0; n_read_address = '0; n_fetch_en = 1'b0; n_pc = '0; n_next_pc = '0;
      model_clear();
      #1;
      n_rst_n = 1'b0;
      test_reset();
      test_strobes();
      test_forward();
      test_back_to_back();
      test_random();
      test_reset_midclear();
      test_noclear();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
